// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader and its byte packer.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } loader_state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; emits a word_valid strobe on the
// fourth byte, or on flush when a partial word is pending (upper lanes padded with zero).
module imem_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        take,
    input  logic        flush,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  count;
    logic [23:0] lanes;

    // Lanes are zeroed after every emitted word, so a flushed partial word is already padded.
    always_comb begin
        word_valid = 1'b0;
        word       = {8'h00, lanes};
        if (take && count == 2'd3) begin
            word_valid = 1'b1;
            word       = {data, lanes};
        end else if (flush && count != 2'd0) begin
            word_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 2'd0;
            lanes <= 24'h0;
        end else if (clear || flush) begin
            count <= 2'd0;
            lanes <= 24'h0;
        end else if (take) begin
            if (count == 2'd3) begin
                count <= 2'd0;
                lanes <= 24'h0;
            end else begin
                count <= count + 2'd1;
                case (count)
                    2'd0:    lanes[7:0]   <= data;
                    2'd1:    lanes[15:8]  <= data;
                    default: lanes[23:16] <= data;
                endcase
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Zero-latency instruction memory for the fetch unit, plus a byte-wide program-load port
// that stalls fetch (stop) while an image is being written.
module imem_loader
    import imem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] FILL_WORD   = NOP_WORD,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   pc,
    output logic [31:0]   mem,
    output logic          addr_err,
    output logic          stop,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [7:0]    load_byte,
    input  logic          load_end,
    output logic [AW:0]   load_words,
    output logic          load_ovf
);

    loader_state_t state;
    logic [AW:0]   wptr;
    logic [31:0]   store [DEPTH_WORDS];

    logic          restart;
    logic          take;
    logic          flush;
    logic          word_valid;
    logic [31:0]   word;
    logic          write_en;
    logic [AW-1:0] idx;
    logic          out_of_range;

    // A load_start inside LOAD wins over a byte in the same cycle; FLUSH ignores all load inputs.
    assign restart  = load_start && (state != FLUSH);
    assign take     = (state == LOAD) && load_valid && !load_start;
    assign flush    = (state == FLUSH);
    assign write_en = word_valid && !wptr[AW];

    imem_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .take       (take),
        .flush      (flush),
        .data       (load_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    // The write pointer doubles as the word count; it stops at DEPTH_WORDS, which saturates load_words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            stop     <= 1'b0;
            wptr     <= '0;
            load_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state    <= LOAD;
                        stop     <= 1'b1;
                        wptr     <= '0;
                        load_ovf <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        wptr     <= '0;
                        load_ovf <= 1'b0;
                    end else begin
                        if (word_valid) begin
                            if (wptr[AW]) load_ovf <= 1'b1;
                            else          wptr     <= wptr + 1'b1;
                        end
                        if (load_end) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (word_valid) begin
                        if (wptr[AW]) load_ovf <= 1'b1;
                        else          wptr     <= wptr + 1'b1;
                    end
                    state <= IDLE;
                    stop  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    stop  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (write_en) store[wptr[AW-1:0]] <= word;
    end

    assign load_words = wptr;

    // No read-during-write bypass: stop is high whenever the array is written.
    assign idx          = pc[AW+1:2];
    assign out_of_range = |pc[31:AW+2];
    assign addr_err     = out_of_range || (pc[1:0] != 2'b00);
    assign mem          = (stop || out_of_range) ? FILL_WORD : store[idx];

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench: two loaders (256 and 4 words) share stimulus and are
// compared against a byte-stream model of the loaded image.
module tb_imem_loader;

    localparam logic [31:0] FILL4 = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_end = 1'b0;
    logic [7:0]  load_byte = 8'h00;
    logic [31:0] pc_manual = 32'h0;
    logic [31:0] pc;
    logic [31:0] mem256, mem4;
    logic        err256, err4, stop256, stop4, ovf256, ovf4;
    logic [8:0]  lw256;
    logic [2:0]  lw4;

    logic        fetch_mode = 1'b0;
    logic [31:0] fetch_pc = 32'h0;
    logic [31:0] fetch_log [16];
    int          stop_cycles = 0;

    logic [31:0] m256 [256];
    bit          kv256 [256];
    logic [31:0] m4 [4];
    bit          kv4 [4];
    int          exp_lw256, exp_lw4;
    bit          exp_ovf256, exp_ovf4;
    bit [7:0]    img [$];
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    assign pc = fetch_mode ? fetch_pc : pc_manual;

    imem_loader #(.DEPTH_WORDS(256)) dut256 (
        .clk(clk), .reset(reset), .pc(pc), .mem(mem256), .addr_err(err256), .stop(stop256),
        .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
        .load_end(load_end), .load_words(lw256), .load_ovf(ovf256)
    );

    imem_loader #(.DEPTH_WORDS(4), .FILL_WORD(FILL4)) dut4 (
        .clk(clk), .reset(reset), .pc(pc), .mem(mem4), .addr_err(err4), .stop(stop4),
        .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
        .load_end(load_end), .load_words(lw4), .load_ovf(ovf4)
    );

    // Minimal fetch unit: advances the PC and logs the instruction whenever stop is low.
    always @(posedge clk) begin
        if (stop256) stop_cycles <= stop_cycles + 1;
        if (!fetch_mode) begin
            fetch_pc <= 32'h0;
        end else if (!stop256) begin
            fetch_log[fetch_pc[5:2]] <= mem256;
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the image is the byte stream grouped four at a time, little-endian, zero padded.
    function automatic void modelCommit(input bit flushed);
        int words;
        logic [31:0] v;
        words = flushed ? (img.size() + 3) / 4 : img.size() / 4;
        for (int w = 0; w < words; w++) begin
            v = 32'h0;
            for (int b = 0; b < 4; b++)
                if (4 * w + b < img.size()) v[8*b +: 8] = img[4*w+b];
            if (w < 256) begin m256[w] = v; kv256[w] = 1'b1; end
            if (w < 4)   begin m4[w]   = v; kv4[w]   = 1'b1; end
        end
        exp_lw256  = (words < 256) ? words : 256;
        exp_ovf256 = (words > 256);
        exp_lw4    = (words < 4) ? words : 4;
        exp_ovf4   = (words > 4);
    endfunction

    task automatic pulseStart(input bit junk);
        if (junk) begin
            load_valid = 1'b1; load_end = 1'b1; load_byte = 8'($urandom);
            tick();
        end
        load_start = 1'b1; load_valid = junk; load_end = junk; load_byte = 8'($urandom);
        tick();
        load_start = 1'b0; load_valid = 1'b0; load_end = 1'b0;
    endtask

    task automatic applyStimulus(input int gap_pct, input bit with_end, input bit end_on_last);
        for (int i = 0; i < img.size(); i++) begin
            if ($urandom_range(99) < gap_pct) begin
                load_byte = 8'($urandom);
                tick();
            end
            load_valid = 1'b1;
            load_byte  = img[i];
            load_end   = with_end && end_on_last && (i == img.size() - 1);
            tick();
            load_valid = 1'b0;
            load_end   = 1'b0;
        end
        if (with_end && !(end_on_last && img.size() != 0)) begin
            load_end = 1'b1;
            tick();
            load_end = 1'b0;
        end
        if (with_end) tick();
    endtask

    task automatic checkReads();
        int i;
        for (int w = 0; w < 256; w++) begin
            if (kv256[w]) begin
                pc_manual = 32'(w * 4); #1;
                checkOutput("rd256", mem256, m256[w]);
                checkOutput("err256_aligned", err256, 0);
            end
        end
        for (int w = 0; w < 4; w++) begin
            if (kv4[w]) begin
                pc_manual = 32'(w * 4); #1;
                checkOutput("rd4", mem4, m4[w]);
            end
        end
        i = $urandom_range(3);
        if (kv4[i]) begin
            pc_manual = 32'(i * 4 + $urandom_range(1, 3)); #1;
            checkOutput("rd4_misaligned", mem4, m4[i]);
            checkOutput("err4_misaligned", err4, 1);
        end
        pc_manual = 32'h10 + 32'($urandom_range(0, 1000)) * 4; #1;
        checkOutput("rd4_oob", mem4, FILL4);
        checkOutput("err4_oob", err4, 1);
    endtask

    task automatic checkAfter(input string tag);
        checkOutput({tag, "_stop256"}, stop256, 0);
        checkOutput({tag, "_stop4"}, stop4, 0);
        checkOutput({tag, "_lw256"}, lw256, exp_lw256);
        checkOutput({tag, "_lw4"}, lw4, exp_lw4);
        checkOutput({tag, "_ovf256"}, ovf256, exp_ovf256);
        checkOutput({tag, "_ovf4"}, ovf4, exp_ovf4);
        checkReads();
    endtask

    task automatic checkStalled(input string tag);
        pc_manual = 32'h0; #1;
        checkOutput({tag, "_stop256"}, stop256, 1);
        checkOutput({tag, "_fill256"}, mem256, 32'h0);
        checkOutput({tag, "_fill4"}, mem4, FILL4);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, k, s0;
        bit restart;

        tick(); tick();
        checkOutput("rst_stop", stop256, 0);
        checkOutput("rst_lw", lw256, 0);
        checkOutput("rst_ovf", ovf4, 0);
        reset = 1'b1;
        tick();

        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        s0 = stop_cycles;
        pulseStart(0);
        checkStalled("t2");
        applyStimulus(0, 1, 0);
        modelCommit(1);
        checkOutput("t2_stop_cycles", stop_cycles - s0, 10);
        pc_manual = 32'h0; #1;
        checkOutput("t2_word0", mem256, 32'h0000_0013);
        pc_manual = 32'h4; #1;
        checkOutput("t2_word1", mem256, 32'h0010_0093);
        checkOutput("t5_err_aligned", err256, 0);
        pc_manual = 32'h6; #1;
        checkOutput("t5_misaligned_word", mem256, 32'h0010_0093);
        checkOutput("t5_misaligned_err", err256, 1);
        pc_manual = 32'd1024; #1;
        checkOutput("t5_oob_word", mem256, 32'h0);
        checkOutput("t5_oob_err", err256, 1);
        checkAfter("t2");
        checkOutput("t2_lw_lit", lw256, 2);

        img = '{8'h78, 8'h56, 8'h34};
        pulseStart(0);
        applyStimulus(0, 1, 1);
        modelCommit(1);
        pc_manual = 32'h0; #1;
        checkOutput("t3_word0", mem256, 32'h0034_5678);
        checkAfter("t3");

        img.delete();
        for (int i = 0; i < 6; i++) img.push_back(8'($urandom));
        pulseStart(0);
        applyStimulus(0, 0, 0);
        reset = 1'b0; #1;
        checkOutput("t1_stop", stop256, 0);
        checkOutput("t1_lw", lw256, 0);
        checkOutput("t1_ovf", ovf256, 0);
        tick();
        reset = 1'b1;
        tick();
        modelCommit(0);
        exp_lw256 = 0; exp_lw4 = 0; exp_ovf256 = 0; exp_ovf4 = 0;
        checkAfter("t1");

        img.delete();
        for (int i = 0; i < 20; i++) img.push_back(8'($urandom));
        pulseStart(0);
        applyStimulus(0, 1, 0);
        modelCommit(1);
        checkOutput("t4_lw4", lw4, 4);
        checkOutput("t4_ovf4", ovf4, 1);
        checkAfter("t4");
        pulseStart(0);
        checkOutput("t4_ovf_cleared", ovf4, 0);
        checkOutput("t4_lw_cleared", lw4, 0);
        img.delete();
        applyStimulus(0, 1, 0);
        modelCommit(1);
        checkAfter("t4b");

        img.delete();
        for (int i = 0; i < 12; i++) img.push_back(8'($urandom));
        pulseStart(0);
        fetch_mode = 1'b1;
        applyStimulus(20, 1, 0);
        modelCommit(1);
        checkOutput("t6_pc_held", fetch_pc, 0);
        tick(); tick(); tick();
        checkOutput("t6_pc_adv", fetch_pc, 12);
        for (int i = 0; i < 3; i++) checkOutput("t6_instr", fetch_log[i], m256[i]);
        fetch_mode = 1'b0;
        tick();

        for (int it = 0; it < 40; it++) begin
            restart = ($urandom_range(3) == 0);
            img.delete();
            if (restart) begin
                n = $urandom_range(0, 10);
                for (int i = 0; i < n; i++) img.push_back(8'($urandom));
                pulseStart(1);
                applyStimulus(30, 0, 0);
                modelCommit(0);
                img.delete();
                pulseStart(0);
            end else begin
                pulseStart(1);
            end
            checkStalled("rnd");
            k = $urandom_range(0, 24);
            for (int i = 0; i < k; i++) img.push_back(8'($urandom));
            applyStimulus(30, 1, 1'($urandom_range(1)));
            modelCommit(1);
            checkAfter("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
